// File: rtl/pulse_avg_framer_pkg.sv
// Shared CVITA definitions for the pulse averaging output framer:
// packet type codes, header bit positions, header byte sizes and FSM states.
package pulse_avg_framer_pkg;

  typedef enum logic [1:0] {
    PKT_DATA = 2'b00,
    PKT_FC   = 2'b01,
    PKT_CMD  = 2'b10,
    PKT_RESP = 2'b11
  } cvita_pkt_type_e;

  typedef enum logic [1:0] {
    S_RESET_HOLD  = 2'd0,
    S_PULSE_START = 2'd1,
    S_IN_PKT      = 2'd2
  } framer_state_e;

  // Header bit positions within the 128-bit CVITA header word
  localparam int HDR_TYPE_MSB  = 127;
  localparam int HDR_TYPE_LSB  = 126;
  localparam int HDR_HAS_TIME  = 125;
  localparam int HDR_EOB       = 124;
  localparam int HDR_SEQ_MSB   = 123;
  localparam int HDR_SEQ_LSB   = 112;
  localparam int HDR_LEN_MSB   = 111;
  localparam int HDR_LEN_LSB   = 96;
  localparam int HDR_SRC_MSB   = 95;
  localparam int HDR_SRC_LSB   = 80;
  localparam int HDR_DST_MSB   = 79;
  localparam int HDR_DST_LSB   = 64;
  localparam int HDR_TIME_MSB  = 63;
  localparam int HDR_TIME_LSB  = 0;

  // Header size in bytes without / with the 64-bit VITA time
  localparam logic [15:0] HDR_BYTES_NO_TIME = 16'd8;
  localparam logic [15:0] HDR_BYTES_TIME    = 16'd16;

  typedef struct packed {
    cvita_pkt_type_e pkt_type;
    logic            has_time;
    logic            eob;
    logic [11:0]     seqnum;
    logic [15:0]     length;
    logic [15:0]     src_sid;
    logic [15:0]     dst_sid;
    logic [63:0]     vita_time;
  } cvita_hdr_t;

  // Packet length in bytes: header plus 4 bytes per sample, 16-bit wrap
  function automatic logic [15:0] cvita_length(input logic has_time, input logic [15:0] n_samples);
    logic [15:0] hdr_bytes;
    hdr_bytes = has_time ? HDR_BYTES_TIME : HDR_BYTES_NO_TIME;
    return hdr_bytes + {n_samples[13:0], 2'b00};
  endfunction

endpackage

// File: rtl/pulse_avg_framer_cvita_hdr_encoder.sv
// Combinational packer: places the CVITA header fields at their bit positions.
module cvita_hdr_encoder
  import pulse_avg_framer_pkg::*;
(
  input  cvita_hdr_t   hdr_i,
  output logic [127:0] hdr_o
);

  // Pack each field into its slot of the header word
  always_comb begin
    hdr_o                             = 128'd0;
    hdr_o[HDR_TYPE_MSB:HDR_TYPE_LSB]  = hdr_i.pkt_type;
    hdr_o[HDR_HAS_TIME]               = hdr_i.has_time;
    hdr_o[HDR_EOB]                    = hdr_i.eob;
    hdr_o[HDR_SEQ_MSB:HDR_SEQ_LSB]    = hdr_i.seqnum;
    hdr_o[HDR_LEN_MSB:HDR_LEN_LSB]    = hdr_i.length;
    hdr_o[HDR_SRC_MSB:HDR_SRC_LSB]    = hdr_i.src_sid;
    hdr_o[HDR_DST_MSB:HDR_DST_LSB]    = hdr_i.dst_sid;
    hdr_o[HDR_TIME_MSB:HDR_TIME_LSB]  = hdr_i.vita_time;
  end

endmodule

// File: rtl/pulse_avg_framer.sv
// Output framer: cuts each averaged pulse into CVITA packets of at most spp
// samples and drives the matching header on o_tuser. Data and handshake are a
// zero-latency pass-through; the header for a packet's first beat is built
// combinationally from the live config inputs so there is no bubble.
module pulse_avg_framer
  import pulse_avg_framer_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MAX_SPP = 2048
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [31:0]      pulse_size,
  input  logic [15:0]      spp,
  input  logic [31:0]      sid,
  input  logic             has_time,
  input  logic [63:0]      pulse_time,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic [127:0]     o_tuser,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [31:0]      pkt_count,
  output logic             err_len
);

  localparam logic [15:0] MAX_SPP_C = 16'(MAX_SPP);

  framer_state_e state_q, state_d;
  logic [31:0] remaining_q, remaining_d;
  logic [15:0] cur_len_q, cur_len_d;
  logic [15:0] beat_q, beat_d;
  logic [15:0] spp_q, spp_d;
  logic        has_time_q, has_time_d;
  logic [63:0] time_q, time_d;
  logic [31:0] sid_q, sid_d;
  logic [11:0] seqnum_q, seqnum_d;
  logic [31:0] pkt_count_q, pkt_count_d;
  logic        err_len_q, err_len_d;

  logic        active_s, hs_s, last_beat_s, counted_end_s, eob_s;
  logic [31:0] ps_size_s, remaining_s, rem_after_s;
  logic [15:0] ps_spp_s, ps_len_s, spp_s, cur_len_s, beat_s, next_len_s;
  logic        has_time_s;
  logic [63:0] time_s;
  logic [31:0] sid_s;
  cvita_hdr_t  hdr_s;
  logic [127:0] hdr_bits_s;

  // Pulse-start candidates: zero-fixup and clamp of the live config inputs
  always_comb begin
    ps_size_s = (pulse_size == 32'd0) ? 32'd1 : pulse_size;
    if (spp == 16'd0) begin
      ps_spp_s = 16'd1;
    end else if (spp > MAX_SPP_C) begin
      ps_spp_s = MAX_SPP_C;
    end else begin
      ps_spp_s = spp;
    end
    ps_len_s = ({16'd0, ps_spp_s} < ps_size_s) ? ps_spp_s : ps_size_s[15:0];
  end

  // Effective packet context: live inputs on a pulse's first beat, latched otherwise
  always_comb begin
    if (state_q == S_PULSE_START) begin
      remaining_s = ps_size_s;
      cur_len_s   = ps_len_s;
      spp_s       = ps_spp_s;
      beat_s      = 16'd0;
      has_time_s  = has_time;
      time_s      = pulse_time;
      sid_s       = sid;
    end else begin
      remaining_s = remaining_q;
      cur_len_s   = cur_len_q;
      spp_s       = spp_q;
      beat_s      = beat_q;
      has_time_s  = has_time_q;
      time_s      = time_q;
      sid_s       = sid_q;
    end
  end

  // Handshake, packet-end and next-packet length decode
  always_comb begin
    active_s      = (state_q != S_RESET_HOLD);
    hs_s          = i_tvalid & o_tready & active_s;
    eob_s         = ({16'd0, cur_len_s} == remaining_s);
    last_beat_s   = (beat_s == (cur_len_s - 16'd1)) | i_tlast;
    counted_end_s = (beat_s == (cur_len_s - 16'd1)) & eob_s;
    rem_after_s   = remaining_s - {16'd0, cur_len_s};
    next_len_s    = ({16'd0, spp_s} < rem_after_s) ? spp_s : rem_after_s[15:0];
  end

  // Header fields for the packet currently on the bus
  always_comb begin
    hdr_s.pkt_type  = PKT_DATA;
    hdr_s.has_time  = has_time_s;
    hdr_s.eob       = eob_s;
    hdr_s.seqnum    = seqnum_q;
    hdr_s.length    = cvita_length(has_time_s, cur_len_s);
    hdr_s.src_sid   = sid_s[31:16];
    hdr_s.dst_sid   = sid_s[15:0];
    hdr_s.vita_time = has_time_s ? time_s : 64'd0;
  end

  cvita_hdr_encoder u_hdr_enc (
    .hdr_i (hdr_s),
    .hdr_o (hdr_bits_s)
  );

  assign o_tdata   = i_tdata;
  assign o_tvalid  = i_tvalid & active_s;
  assign i_tready  = o_tready & active_s;
  assign o_tlast   = last_beat_s & active_s;
  assign o_tuser   = active_s ? hdr_bits_s : 128'd0;
  assign pkt_count = pkt_count_q;
  assign err_len   = err_len_q;

  // Next-state logic: beat counting, packet/pulse boundaries, counters
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cur_len_d   = cur_len_q;
    beat_d      = beat_q;
    spp_d       = spp_q;
    has_time_d  = has_time_q;
    time_d      = time_q;
    sid_d       = sid_q;
    seqnum_d    = seqnum_q;
    pkt_count_d = pkt_count_q;
    err_len_d   = err_len_q;
    case (state_q)
      S_RESET_HOLD: begin
        state_d = S_PULSE_START;
      end
      S_PULSE_START, S_IN_PKT: begin
        if (hs_s) begin
          spp_d      = spp_s;
          has_time_d = has_time_s;
          if (last_beat_s) begin
            seqnum_d    = seqnum_q + 12'd1;
            pkt_count_d = pkt_count_q + 32'd1;
            time_d      = time_s + {48'd0, cur_len_s};
            remaining_d = rem_after_s;
            cur_len_d   = next_len_s;
            beat_d      = 16'd0;
            sid_d       = sid;
            // i_tlast must coincide exactly with the counted end of the pulse
            if (i_tlast != counted_end_s) begin
              err_len_d = 1'b1;
            end else begin
              err_len_d = err_len_q;
            end
            if ((rem_after_s == 32'd0) || i_tlast) begin
              state_d = S_PULSE_START;
            end else begin
              state_d = S_IN_PKT;
            end
          end else begin
            beat_d      = beat_s + 16'd1;
            remaining_d = remaining_s;
            cur_len_d   = cur_len_s;
            time_d      = time_s;
            sid_d       = sid_s;
            state_d     = S_IN_PKT;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = S_RESET_HOLD;
      end
    endcase
  end

  // State and context registers; reset and clear both return to RESET_HOLD
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q     <= S_RESET_HOLD;
      remaining_q <= 32'd0;
      cur_len_q   <= 16'd0;
      beat_q      <= 16'd0;
      spp_q       <= 16'd0;
      has_time_q  <= 1'b0;
      time_q      <= 64'd0;
      sid_q       <= 32'd0;
      seqnum_q    <= 12'd0;
      pkt_count_q <= 32'd0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      cur_len_q   <= cur_len_d;
      beat_q      <= beat_d;
      spp_q       <= spp_d;
      has_time_q  <= has_time_d;
      time_q      <= time_d;
      sid_q       <= sid_d;
      seqnum_q    <= seqnum_d;
      pkt_count_q <= pkt_count_d;
      err_len_q   <= err_len_d;
    end
  end

endmodule

// File: tb/tb_pulse_avg_framer.sv
// Scoreboard bench for pulse_avg_framer: stimulus pushes expected output beats
// (data, tlast, header) into a queue; a negedge monitor pops and compares
// every beat the DUT presents with o_tvalid & o_tready.
module tb_pulse_avg_framer;

  logic         clk = 1'b0;
  logic         reset, clear;
  logic [31:0]  pulse_size;
  logic [15:0]  spp;
  logic [31:0]  sid;
  logic         has_time;
  logic [63:0]  pulse_time;
  logic [31:0]  i_tdata;
  logic         i_tlast, i_tvalid, i_tready;
  logic [31:0]  o_tdata;
  logic [127:0] o_tuser;
  logic         o_tlast, o_tvalid;
  logic         o_tready = 1'b0;
  logic [31:0]  pkt_count;
  logic         err_len;

  typedef struct {
    logic [31:0]  data;
    logic         last;
    logic [127:0] user;
  } beat_t;

  beat_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          rand_ready = 1'b0;
  logic [31:0] data_ctr = 32'd0;

  localparam logic [31:0] SID_A = 32'hABCD_1234;

  always #5 clk = ~clk;

  pulse_avg_framer #(.WIDTH(32), .MAX_SPP(2048)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .pulse_size(pulse_size), .spp(spp), .sid(sid), .has_time(has_time), .pulse_time(pulse_time),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .pkt_count(pkt_count), .err_len(err_len)
  );

  // Downstream ready: always 1, or a coin flip per cycle in random mode
  always @(posedge clk) begin
    #1;
    o_tready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
  end

  // Monitor: compare every accepted output beat against the scoreboard
  always @(negedge clk) begin : mon
    beat_t e;
    if (o_tvalid && o_tready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat got data=%h last=%b user=%h", o_tdata, o_tlast, o_tuser);
      end else begin
        e = exp_q.pop_front();
        if (o_tdata !== e.data || o_tlast !== e.last || o_tuser !== e.user) begin
          errors++;
          $display("FAIL beat got data=%h last=%b user=%h want data=%h last=%b user=%h",
                   o_tdata, o_tlast, o_tuser, e.data, e.last, e.user);
        end
      end
    end
  end

  function automatic logic [127:0] mk_hdr(input logic ht, input logic eob, input logic [11:0] seq,
                                          input logic [15:0] len, input logic [31:0] s, input logic [63:0] t);
    return {2'b00, ht, eob, seq, len, s, t};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Push n expected beats of one packet sharing one header
  task automatic push_pkt(input int n, input logic [31:0] base, input logic [15:0] len, input logic ht,
                          input logic eob, input logic [11:0] seq, input logic [31:0] s,
                          input logic [63:0] t, input bit last_on_end);
    beat_t b;
    for (int j = 0; j < n; j++) begin
      b.data = base + 32'(j);
      b.last = last_on_end && (j == n - 1);
      b.user = mk_hdr(ht, eob, seq, len, s, t);
      exp_q.push_back(b);
    end
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic l, input bit thr);
    bit hs;
    int guard;
    if (thr) begin
      guard = 0;
      while ($urandom_range(1, 0) == 1 && guard < 8) begin
        i_tvalid = 1'b0;
        @(posedge clk); #1;
        guard++;
      end
    end
    i_tdata  = d;
    i_tlast  = l;
    i_tvalid = 1'b1;
    hs = 1'b0;
    for (guard = 0; guard < 1000 && !hs; guard++) begin
      @(negedge clk);
      hs = i_tready;
      @(posedge clk); #1;
    end
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout got=no_ready want=ready data=%h", d);
    end
  endtask

  task automatic send_pulse(input logic [31:0] sz, input logic [15:0] sp, input logic ht,
                            input logic [63:0] t, input logic [31:0] s, input int n,
                            input int tlast_idx, input bit thr);
    pulse_size = sz;
    spp        = sp;
    has_time   = ht;
    pulse_time = t;
    sid        = s;
    for (int i = 0; i < n; i++) begin
      drive_beat(data_ctr, (i == tlast_idx), thr);
      data_ctr++;
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  // Called in the RESET_HOLD cycle: outputs must read reset values even with input valid
  task automatic hold_check();
    i_tvalid = 1'b1;
    i_tlast  = 1'b1;
    @(negedge clk);
    check("hold_o_tvalid", 64'(o_tvalid), 64'd0);
    check("hold_i_tready", 64'(i_tready), 64'd0);
    check("hold_o_tlast", 64'(o_tlast), 64'd0);
    check("hold_o_tuser_hi", o_tuser[127:64], 64'd0);
    check("hold_o_tuser_lo", o_tuser[63:0], 64'd0);
    check("hold_pkt_count", 64'(pkt_count), 64'd0);
    check("hold_err_len", 64'(err_len), 64'd0);
    @(posedge clk); #1;
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic clear_dut();
    clear    = 1'b1;
    i_tvalid = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;
    hold_check();
  endtask

  task automatic drain();
    for (int k = 0; k < 3000 && exp_q.size() != 0; k++) @(negedge clk);
    check("drain_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] base;
    logic [11:0] exp_seq;
    int          exp_pkts;
    int          sz, sp, esz, esp, rem, cl, off;
    logic        ht;
    logic [63:0] t, tt;
    logic [31:0] sd;

    reset = 1'b1; clear = 1'b0;
    pulse_size = 32'd0; spp = 16'd0; sid = 32'd0; has_time = 1'b0; pulse_time = 64'd0;
    i_tdata = 32'd0; i_tlast = 1'b0; i_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    hold_check();

    // 10 samples, spp 4, with time: 4/4/2 samples, lengths 32/32/24
    base = data_ctr;
    push_pkt(4, base,          16'd32, 1'b1, 1'b0, 12'd0, SID_A, 64'd1000, 1'b1);
    push_pkt(4, base + 32'd4,  16'd32, 1'b1, 1'b0, 12'd1, SID_A, 64'd1004, 1'b1);
    push_pkt(2, base + 32'd8,  16'd24, 1'b1, 1'b1, 12'd2, SID_A, 64'd1008, 1'b1);
    send_pulse(32'd10, 16'd4, 1'b1, 64'd1000, SID_A, 10, 9, 1'b0);
    drain();
    check("t1_pkt_count", 64'(pkt_count), 64'd3);
    check("t1_err_len", 64'(err_len), 64'd0);

    // 8 samples, spp 8, no time: one packet, length 40, time 0; second pulse seqnum 1
    clear_dut();
    base = data_ctr;
    push_pkt(8, base, 16'd40, 1'b0, 1'b1, 12'd0, 32'h0001_0002, 64'd0, 1'b1);
    send_pulse(32'd8, 16'd8, 1'b0, 64'd5555, 32'h0001_0002, 8, 7, 1'b0);
    base = data_ctr;
    push_pkt(8, base, 16'd40, 1'b0, 1'b1, 12'd1, 32'h0001_0002, 64'd0, 1'b1);
    send_pulse(32'd8, 16'd8, 1'b0, 64'd7777, 32'h0001_0002, 8, 7, 1'b0);
    drain();
    check("t2_pkt_count", 64'(pkt_count), 64'd2);

    // Early i_tlast on sample 6 of a 10-sample pulse
    clear_dut();
    base = data_ctr;
    push_pkt(4, base,         16'd32, 1'b1, 1'b0, 12'd0, SID_A, 64'd1000, 1'b1);
    push_pkt(3, base + 32'd4, 16'd32, 1'b1, 1'b0, 12'd1, SID_A, 64'd1004, 1'b1);
    send_pulse(32'd10, 16'd4, 1'b1, 64'd1000, SID_A, 7, 6, 1'b0);
    base = data_ctr;
    push_pkt(4, base, 16'd32, 1'b1, 1'b1, 12'd2, SID_A, 64'd2000, 1'b1);
    send_pulse(32'd4, 16'd4, 1'b1, 64'd2000, SID_A, 4, 3, 1'b0);
    drain();
    check("t3_err_len", 64'(err_len), 64'd1);
    check("t3_pkt_count", 64'(pkt_count), 64'd3);

    // Clear mid-packet: partial packet abandoned, next pulse restarts at seqnum 0
    clear_dut();
    base = data_ctr;
    push_pkt(2, base, 16'd32, 1'b1, 1'b0, 12'd0, SID_A, 64'd1000, 1'b0);
    send_pulse(32'd10, 16'd4, 1'b1, 64'd1000, SID_A, 2, -1, 1'b0);
    clear_dut();
    base = data_ctr;
    push_pkt(4, base, 16'd32, 1'b1, 1'b1, 12'd0, SID_A, 64'd3000, 1'b1);
    send_pulse(32'd4, 16'd4, 1'b1, 64'd3000, SID_A, 4, 3, 1'b0);
    drain();
    check("t4_pkt_count", 64'(pkt_count), 64'd1);

    // 4097 one-sample packets: seqnum wraps to 0 on the last one
    clear_dut();
    base = data_ctr;
    for (int i = 0; i < 4097; i++) begin
      push_pkt(1, base + 32'(i), 16'd12, 1'b0, (i == 4096), 12'(i), SID_A, 64'd0, 1'b1);
    end
    send_pulse(32'd4097, 16'd1, 1'b0, 64'd0, SID_A, 4097, 4096, 1'b0);
    drain();
    check("t5_pkt_count", 64'(pkt_count), 64'd4097);

    // 1000 random pulses with 50% valid/ready throttling
    clear_dut();
    rand_ready = 1'b1;
    exp_seq  = 12'd0;
    exp_pkts = 0;
    for (int p = 0; p < 1000; p++) begin
      sz  = $urandom_range(12, 0);
      sp  = $urandom_range(5, 0);
      ht  = 1'($urandom_range(1, 0));
      t   = {$urandom, $urandom};
      sd  = $urandom;
      esz = (sz == 0) ? 1 : sz;
      esp = (sp == 0) ? 1 : sp;
      rem = esz;
      off = 0;
      tt  = t;
      base = data_ctr;
      while (rem > 0) begin
        cl = (rem < esp) ? rem : esp;
        push_pkt(cl, base + 32'(off), 16'(8 + 8 * int'(ht) + 4 * cl), ht, (cl == rem), exp_seq, sd,
                 ht ? tt : 64'd0, 1'b1);
        exp_seq++;
        exp_pkts++;
        rem -= cl;
        off += cl;
        tt  += 64'(cl);
      end
      send_pulse(32'(sz), 16'(sp), ht, t, sd, esz, esz - 1, 1'b1);
    end
    drain();
    rand_ready = 1'b0;
    check("t6_pkt_count", 64'(pkt_count), 64'(exp_pkts));
    check("t6_err_len", 64'(err_len), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_avg_framer.md
# pulse_avg_framer

Output framer for the pulse averaging datapath. Takes the averaged-pulse sample stream produced by the averaging core's readout and cuts each pulse into CVITA data packets of at most `spp` samples. For every packet it builds the 128-bit CVITA header on `o_tuser`: sequence number, length, SID, EOB and VITA time. It is the transmit-side counterpart to the averaging core's header decode and sits between the accumulator readout and the block's output AXI-stream port.

## Interface
Parameters:
- `WIDTH`, 32: sample width in bits; must be 32 (one sample per 4-byte CVITA payload word).
- `MAX_SPP`, 2048: maximum legal `spp`; larger values are clamped to `MAX_SPP`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `clear` in 1: synchronous soft clear, same effect as `reset`.
- `pulse_size` in 32: samples per pulse; sampled at pulse start; 0 is treated as 1.
- `spp` in 16: samples per packet; sampled at pulse start; 0 is treated as 1.
- `sid` in 32: {src_sid, dst_sid}; sampled at packet start.
- `has_time` in 1: insert VITA time; sampled at pulse start.
- `pulse_time` in 64: VITA time of the pulse's first sample; sampled with the first input beat of a pulse.
- `i_tdata` in 32, `i_tlast` in 1, `i_tvalid` in 1, `i_tready` out 1: averaged samples; `i_tlast` marks the last sample of a pulse.
- `o_tdata` out 32, `o_tuser` out 128, `o_tlast` out 1, `o_tvalid` out 1, `o_tready` in 1: packetized output.
- `pkt_count` out 32: packets emitted since reset.
- `err_len` out 1: sticky; `i_tlast` disagreed with `pulse_size`.

## Operation
- Data path is a combinational pass-through: `o_tdata = i_tdata`, `o_tvalid = i_tvalid & active`, `i_tready = o_tready & active`. `active` is 1 in every state except RESET_HOLD.
- States:
  - RESET_HOLD: one cycle after reset/clear.
  - PULSE_START: waiting for the first beat of a pulse.
  - IN_PKT.
- PULSE_START: latch `pulse_size`, `spp`, `has_time` and `pulse_time`. Set `remaining = pulse_size` and `cur_len = min(spp, remaining)`. Build the header, then go to IN_PKT. The header is also driven combinationally on the first beat, so there is no bubble.
- IN_PKT: `beat` counter 0..`cur_len`-1. `o_tlast = (beat == cur_len-1) | i_tlast`.
- On a last-beat handshake:
  - `remaining -= cur_len`.
  - `time += cur_len`.
  - `seqnum += 1` (12-bit wrap 4095 -> 0).
  - `pkt_count += 1` (32-bit wrap).
  - If `remaining == 0` or `i_tlast` -> PULSE_START; otherwise compute the next `cur_len` and header, and stay in IN_PKT.
- Header fields:
  - `pkt_type` = 0 (data).
  - `eob` = 1 iff `cur_len == remaining` (last packet of pulse).
  - `length` = 8 + 8·`has_time` + 4·`cur_len`, truncated to 16 bits.
  - `vita_time` = latched time (0 when `has_time` = 0).
- Early `i_tlast` (before `remaining` is exhausted): end the packet and pulse at that beat and set `err_len`. The header's length field stays as emitted.
- Late `i_tlast` (no `i_tlast` on the final counted sample): end the pulse by count and set `err_len`. The trailing samples start a new pulse.
- `o_tuser` is stable from the first beat through the last beat of each packet.
- The `seqnum` counter persists across pulses; only reset/clear zeroes it.

## Timing
- Zero-cycle latency, data and handshake; throughput is 1 sample/cycle with no inter-packet bubble.
- Reset values: `o_tvalid` 0, `i_tready` 0, `o_tlast` 0, `o_tuser` 0, `pkt_count` 0, `err_len` 0, `seqnum` 0.
- Reset/clear mid-packet: the partial packet is abandoned and the state returns to RESET_HOLD. Downstream must tolerate the truncated packet, because reset is global.
- `o_tready` low stalls everything; counters advance only on `o_tvalid & o_tready`.
- Config inputs change only at pulse boundaries; a mid-pulse change takes effect at the next pulse (`sid` at the next packet).

## Structure
- Shared package: CVITA `pkt_type` codes, header bit positions {pkt_type[127:126], has_time[125], eob[124], seqnum[123:112], length[111:96], src_sid[95:80], dst_sid[79:64], time[63:0]}, and the header byte constants 8/16.
- One sub-module: `cvita_hdr_encoder` (combinational field packer), instantiated once.

## Test plan
- `pulse_size`=10, `spp`=4, `has_time`=1, `pulse_time`=1000 -> 3 packets:
  - lengths 4/4/2 samples, length field 32/32/24;
  - time 1000/1004/1008;
  - seqnum 0/1/2;
  - eob only on the third; `o_tlast` at beats 3, 7, 9.
- `pulse_size`=8, `spp`=8, `has_time`=0 -> one packet, length field 40, time 0, eob=1; a second pulse gives seqnum 1.
- Random `o_tready` and `i_tvalid` at 50% over 1000 pulses -> no data lost or duplicated, and `o_tuser` constant within every packet.
- `pulse_size`=10, `i_tlast` at sample 6 -> second packet ends at sample 6, `err_len`=1, next pulse starts clean with seqnum 2.
- 4097 packets -> seqnum wraps to 0 on packet 4097, `pkt_count`=4097.
- `clear` asserted mid-packet -> all outputs at reset values next cycle; following pulse starts at seqnum 0.
